// File: rtl/float_multiply_seq_32bit.sv
// Purpose     : sequential IEEE-754 single-precision multiplier, shift-add mantissa, truncating.
// Latency     : done pulses in the cycle after the 25th edge following the accepting edge; 26-cycle throughput.
// Backpressure: none; start is taken only in IDLE, and start while busy is ignored.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start                request, sampled only when idle
//   multiplicand         operand A, captured on the accepted start
//   multiplier           operand B, captured on the accepted start
//   product              result, held until the next result is written
//   busy                 high from the accepted start until done
//   done                 one-cycle pulse, product valid in the same cycle
//
// Optional feature: define SPECIAL_CASE_EN for inf/NaN/zero handling and exponent
// overflow/underflow clamping. Without it, the exponent wraps modulo 256 and the
// hidden bit is always 1.
module float_multiply_seq_32bit #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic [31:0] product,
  output logic        busy,
  output logic        done
);

  localparam int ACC_W  = 2 * MANT_W;
  localparam int FRAC_W = MANT_W - 1;
  localparam int CNT_W  = $clog2(MANT_W);
  // Two guard bits so the biased sum can be negative or exceed the field range.
  localparam int XW     = EXP_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   acc;
  logic [MANT_W-1:0]  mant_a;
  logic [MANT_W-1:0]  mant_b;
  logic               sign;
  logic [XW-1:0]      exp_sum;

  // Operand fields as presented on the inputs (used only on the accepting edge).
  logic [EXP_W-1:0]   a_exp, b_exp;
  logic [FRAC_W-1:0]  a_frac, b_frac;
  logic [XW-1:0]      exp_sum_nxt;

  assign a_exp  = multiplicand[30 -: EXP_W];
  assign b_exp  = multiplier[30 -: EXP_W];
  assign a_frac = multiplicand[FRAC_W-1:0];
  assign b_frac = multiplier[FRAC_W-1:0];
  assign exp_sum_nxt = {2'b00, a_exp} + {2'b00, b_exp} - XW'(BIAS);

  // Normalisation of the finished accumulator.
  logic               norm_hi;
  logic [FRAC_W-1:0]  frac_fin;
  logic [XW-1:0]      exp_fin;
  logic [31:0]        result_nxt;

  assign norm_hi  = acc[ACC_W-1];
  assign frac_fin = norm_hi ? acc[ACC_W-2 -: FRAC_W] : acc[ACC_W-3 -: FRAC_W];
  assign exp_fin  = exp_sum + XW'(norm_hi);

`ifdef SPECIAL_CASE_EN
  // Operand class is resolved at capture time so NORM only has to select.
  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  cls_t cls;
  cls_t cls_nxt;
  logic a_max, b_max, a_zero, b_zero;

  assign a_max  = (a_exp == '1);
  assign b_max  = (b_exp == '1);
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);

  always_comb begin
    cls_nxt = CLS_NONE;
    if (a_max || b_max) begin
      // inf x 0 and any NaN input give the canonical quiet NaN.
      if ((a_max && ((a_frac != '0) || b_zero)) || (b_max && ((b_frac != '0) || a_zero)))
        cls_nxt = CLS_NAN;
      else
        cls_nxt = CLS_INF;
    end else if (a_zero || b_zero) begin
      cls_nxt = CLS_ZERO;
    end
  end

  logic unused_bits;
  assign unused_bits = ^acc[ACC_W-MANT_W-2:0];

  always_comb begin
    result_nxt = {sign, exp_fin[EXP_W-1:0], frac_fin};
    case (cls)
      CLS_NAN:  result_nxt = 32'h7FC0_0000;
      CLS_INF:  result_nxt = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      CLS_ZERO: result_nxt = {sign, 31'h0};
      default: begin
        if ($signed(exp_fin) >= $signed(XW'(255)))
          result_nxt = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        else if ($signed(exp_fin) <= $signed(XW'(0)))
          result_nxt = {sign, 31'h0};
      end
    endcase
  end
`else
  // Low product bits are discarded by truncation; the exponent guard bits are
  // dropped because the exponent deliberately wraps.
  logic unused_bits;
  assign unused_bits = ^{acc[ACC_W-MANT_W-2:0], exp_fin[XW-1:EXP_W]};

  always_comb begin
    result_nxt = {sign, exp_fin[EXP_W-1:0], frac_fin};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mant_a  <= '0;
      mant_b  <= '0;
      sign    <= 1'b0;
      exp_sum <= '0;
`ifdef SPECIAL_CASE_EN
      cls     <= CLS_NONE;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mant_a  <= {1'b1, a_frac};
            mant_b  <= {1'b1, b_frac};
            sign    <= multiplicand[31] ^ multiplier[31];
            exp_sum <= exp_sum_nxt;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
`ifdef SPECIAL_CASE_EN
            cls     <= cls_nxt;
`endif
            state   <= MUL;
          end
        end
        MUL: begin
          // One partial product per clock, LSB of the multiplier first.
          if (mant_b[cnt])
            acc <= acc + (ACC_W'(mant_a) << cnt);
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MANT_W - 1))
            state <= NORM;
        end
        NORM: begin
          product <= result_nxt;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
